// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between fetch, data and an
// optional host port (enabled by defining HOST_PORT_EN), fixed priority with a fetch starvation guard.
module mem_port_arbiter #(
  parameter int AW           = 6,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [31:0]   i_addr,
  output logic [31:0]   i_rdata,
  output logic          i_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_valid,
`ifdef HOST_PORT_EN
  input  logic          h_req,
  input  logic          h_we,
  input  logic [31:0]   h_addr,
  input  logic [31:0]   h_wdata,
  output logic [31:0]   h_rdata,
  output logic          h_valid,
`endif
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          stall,
  output logic          align_err
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic [1:0] {OWN_I, OWN_D, OWN_H} owner_t;

  state_t        state, state_next;
  owner_t        owner, grant;
  logic [CW-1:0] starve_cnt;
  logic          cur_we;
  logic [31:0]   i_rdata_q, d_rdata_q;

  logic          host_req, host_we;
  logic [31:0]   host_addr, host_wdata;

  logic          arb_point, i_elig, d_elig, h_elig, grant_any, starve_hit;
  logic          sel_we;
  logic [31:0]   sel_addr, sel_wdata;
  logic          unused_addr_bits;

`ifdef HOST_PORT_EN
  logic [31:0]   h_rdata_q;
  assign host_req   = h_req;
  assign host_we    = h_we;
  assign host_addr  = h_addr;
  assign host_wdata = h_wdata;
`else
  assign host_req   = 1'b0;
  assign host_we    = 1'b0;
  assign host_addr  = '0;
  assign host_wdata = '0;
`endif

  // A port finishing in this RESP cycle may not be re-granted until it sees its valid.
  assign arb_point  = (state == IDLE) || (state == RESP);
  assign i_elig     = i_req    && !((state == RESP) && (owner == OWN_I));
  assign d_elig     = d_req    && !((state == RESP) && (owner == OWN_D));
  assign h_elig     = host_req && !((state == RESP) && (owner == OWN_H));
  assign starve_hit = (starve_cnt == CW'(STARVE_LIMIT));
  assign grant_any  = arb_point && (i_elig || d_elig || h_elig);

  always_comb begin
    grant = OWN_I;
    if (i_elig && starve_hit) grant = OWN_I;
    else if (h_elig)          grant = OWN_H;
    else if (d_elig)          grant = OWN_D;
    else                      grant = OWN_I;
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = i_addr;
    sel_wdata = '0;
    case (grant)
      OWN_D: begin
        sel_we    = d_we;
        sel_addr  = d_addr;
        sel_wdata = d_wdata;
      end
      OWN_H: begin
        sel_we    = host_we;
        sel_addr  = host_addr;
        sel_wdata = host_wdata;
      end
      default: begin
        sel_we    = 1'b0;
        sel_addr  = i_addr;
        sel_wdata = '0;
      end
    endcase
  end

  assign unused_addr_bits = ^sel_addr[31:AW+2];

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = grant_any ? ISSUE : IDLE;
      ISSUE:   state_next = RESP;
      RESP:    state_next = grant_any ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Valid is gated by reset so a pulse due in the reset cycle is dropped.
  always_comb begin
    i_valid = reset && (state == RESP) && (owner == OWN_I);
    d_valid = reset && (state == RESP) && (owner == OWN_D);
    stall   = (i_req && !i_valid) || (d_req && !d_valid);
  end

`ifdef HOST_PORT_EN
  assign h_valid = reset && (state == RESP) && (owner == OWN_H);
  assign h_rdata = (h_valid && !cur_we) ? mem_rdata : h_rdata_q;
`endif

  // Read data bypasses straight from the RAM during the valid cycle, then is held.
  assign i_rdata = (i_valid && !cur_we) ? mem_rdata : i_rdata_q;
  assign d_rdata = (d_valid && !cur_we) ? mem_rdata : d_rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      owner      <= OWN_I;
      cur_we     <= 1'b0;
      starve_cnt <= '0;
      align_err  <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      mem_en <= grant_any;
      mem_we <= grant_any && sel_we;
      if (grant_any) begin
        mem_addr  <= sel_addr[AW+1:2];
        mem_wdata <= sel_wdata;
        owner     <= grant;
        cur_we    <= sel_we;
        if (sel_addr[1:0] != 2'b00) align_err <= 1'b1;
      end
      if (grant_any && (grant == OWN_I))
        starve_cnt <= '0;
      else if (arb_point && i_elig)
        starve_cnt <= starve_cnt + CW'(1);
      if (i_valid && !cur_we) i_rdata_q <= mem_rdata;
      if (d_valid && !cur_we) d_rdata_q <= mem_rdata;
    end
  end

`ifdef HOST_PORT_EN
  always_ff @(posedge clk) begin
    if (!reset)                  h_rdata_q <= '0;
    else if (h_valid && !cur_we) h_rdata_q <= mem_rdata;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a behavioural synchronous RAM;
// the host-port sequence is only built when HOST_PORT_EN is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_valid, d_valid;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall, align_err;
`ifdef HOST_PORT_EN
  logic        h_req = 1'b0, h_we = 1'b0;
  logic [31:0] h_addr = 32'h0, h_wdata = 32'h0;
  logic [31:0] h_rdata;
  logic        h_valid;
`endif

  logic [31:0] ram [64];
  logic        ram_loaded = 1'b0;
  int          tests = 0;
  int          failed = 0;

  mem_port_arbiter #(.AW(6), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
`ifdef HOST_PORT_EN
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rdata(h_rdata), .h_valid(h_valid),
`endif
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall), .align_err(align_err)
  );

  always #5 clk = ~clk;

  // Read-before-write synchronous RAM; word k preloads to 0x1000_0000 + k.
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int k = 0; k < 64; k++) ram[k] <= 32'h1000_0000 + k;
      ram_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs just after a rising edge, then return at the falling edge for sampling.
  task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] dwd);
    @(posedge clk);
    #1;
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dwd;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;

    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("rst_mem_en",    {31'b0, mem_en},    32'd0);
    checkOutput("rst_mem_we",    {31'b0, mem_we},    32'd0);
    checkOutput("rst_mem_addr",  {26'b0, mem_addr},  32'd0);
    checkOutput("rst_mem_wdata", mem_wdata,          32'd0);
    checkOutput("rst_i_valid",   {31'b0, i_valid},   32'd0);
    checkOutput("rst_d_valid",   {31'b0, d_valid},   32'd0);
    checkOutput("rst_align_err", {31'b0, align_err}, 32'd0);
    checkOutput("rst_i_rdata",   i_rdata,            32'd0);
    checkOutput("rst_d_rdata",   d_rdata,            32'd0);

    // Fetch of word 0 straight out of reset.
    @(posedge clk); #1; reset = 1'b1; i_req = 1'b1; i_addr = 32'd0;
    @(negedge clk);
    checkOutput("f0_c0_stall",  {31'b0, stall},   32'd1);
    checkOutput("f0_c0_mem_en", {31'b0, mem_en},  32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("f0_c1_mem_en", {31'b0, mem_en},  32'd1);
    checkOutput("f0_c1_mem_we", {31'b0, mem_we},  32'd0);
    checkOutput("f0_c1_stall",  {31'b0, stall},   32'd1);
    checkOutput("f0_c1_valid",  {31'b0, i_valid}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("f0_c2_valid",  {31'b0, i_valid}, 32'd1);
    checkOutput("f0_c2_rdata",  i_rdata,          32'h1000_0000);
    checkOutput("f0_c2_stall",  {31'b0, stall},   32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("f0_c3_valid",  {31'b0, i_valid}, 32'd0);
    checkOutput("f0_c3_mem_en", {31'b0, mem_en},  32'd0);
    checkOutput("f0_c3_hold",   i_rdata,          32'h1000_0000);

    // Store 8 to byte 84, then load it back.
    applyStimulus(0, 0, 1, 1, 32'd84, 32'd8);
    checkOutput("st_c0_stall",   {31'b0, stall},   32'd1);
    applyStimulus(0, 0, 1, 1, 32'd84, 32'd8);
    checkOutput("st_c1_mem_en",  {31'b0, mem_en},  32'd1);
    checkOutput("st_c1_mem_we",  {31'b0, mem_we},  32'd1);
    checkOutput("st_c1_addr",    {26'b0, mem_addr}, 32'd21);
    checkOutput("st_c1_wdata",   mem_wdata,        32'd8);
    applyStimulus(0, 0, 1, 1, 32'd84, 32'd8);
    checkOutput("st_c2_valid",   {31'b0, d_valid}, 32'd1);
    checkOutput("st_c2_rdata",   d_rdata,          32'd0);
    applyStimulus(0, 0, 1, 0, 32'd84, 32'd0);
    applyStimulus(0, 0, 1, 0, 32'd84, 32'd0);
    checkOutput("ld_c1_mem_we",  {31'b0, mem_we},  32'd0);
    applyStimulus(0, 0, 1, 0, 32'd84, 32'd0);
    checkOutput("ld_c2_valid",   {31'b0, d_valid}, 32'd1);
    checkOutput("ld_c2_rdata",   d_rdata,          32'd8);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Fetch of byte 8 and load of byte 84 together: data first, fetch two cycles later.
    applyStimulus(1, 32'd8, 1, 0, 32'd84, 0);
    applyStimulus(1, 32'd8, 1, 0, 32'd84, 0);
    checkOutput("both_c1_addr",   {26'b0, mem_addr}, 32'd21);
    applyStimulus(1, 32'd8, 1, 0, 32'd84, 0);
    checkOutput("both_c2_dvalid", {31'b0, d_valid}, 32'd1);
    checkOutput("both_c2_ivalid", {31'b0, i_valid}, 32'd0);
    checkOutput("both_c2_drdata", d_rdata,          32'd8);
    checkOutput("both_c2_stall",  {31'b0, stall},   32'd1);
    applyStimulus(1, 32'd8, 0, 0, 0, 0);
    checkOutput("both_c3_mem_en", {31'b0, mem_en},  32'd1);
    checkOutput("both_c3_addr",   {26'b0, mem_addr}, 32'd2);
    applyStimulus(1, 32'd8, 0, 0, 0, 0);
    checkOutput("both_c4_ivalid", {31'b0, i_valid}, 32'd1);
    checkOutput("both_c4_irdata", i_rdata,          32'h1000_0002);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Misaligned load from byte 82 uses word 20 and sets the sticky flag.
    applyStimulus(0, 0, 1, 0, 32'd82, 0);
    checkOutput("mis_c0_err",   {31'b0, align_err}, 32'd0);
    applyStimulus(0, 0, 1, 0, 32'd82, 0);
    checkOutput("mis_c1_err",   {31'b0, align_err}, 32'd1);
    checkOutput("mis_c1_addr",  {26'b0, mem_addr},  32'd20);
    applyStimulus(0, 0, 1, 0, 32'd82, 0);
    checkOutput("mis_c2_rdata", d_rdata,            32'h1000_0014);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("mis_sticky",   {31'b0, align_err}, 32'd1);

    // Reset during the ISSUE cycle of a store of 0x55 to byte 80.
    applyStimulus(0, 0, 1, 1, 32'd80, 32'h55);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    checkOutput("rsti_c1_mem_en", {31'b0, mem_en},  32'd1);
    applyStimulus(0, 0, 1, 1, 32'd80, 32'h55);
    checkOutput("rsti_c2_dvalid", {31'b0, d_valid}, 32'd0);
    checkOutput("rsti_c2_mem_en", {31'b0, mem_en},  32'd0);
    checkOutput("rsti_ram20",     ram[20],          32'h55);
    checkOutput("rsti_err_clr",   {31'b0, align_err}, 32'd0);
    @(posedge clk); #1; reset = 1'b1; d_req = 1'b0; d_we = 1'b0; i_req = 1'b1; i_addr = 32'd80;
    @(negedge clk);
    applyStimulus(1, 32'd80, 0, 0, 0, 0);
    checkOutput("rsti_f_mem_en",  {31'b0, mem_en},  32'd1);
    applyStimulus(1, 32'd80, 0, 0, 0, 0);
    checkOutput("rsti_f_valid",   {31'b0, i_valid}, 32'd1);
    checkOutput("rsti_f_rdata",   i_rdata,          32'h55);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Reset low in the RESP cycle suppresses that valid pulse.
    applyStimulus(0, 0, 1, 0, 32'd4, 0);
    applyStimulus(0, 0, 1, 0, 32'd4, 0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    checkOutput("rstr_dvalid", {31'b0, d_valid}, 32'd0);
    @(posedge clk); #1; reset = 1'b1; d_req = 1'b0;
    @(negedge clk);

`ifdef HOST_PORT_EN
    begin
      // Host, data and fetch all held: expected completion order h,d,h,d,i,h.
      logic [1:0] order [$];
      logic [1:0] exp_order [6];
      exp_order = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd0, 2'd2};
      @(posedge clk); #1; h_req = 1'b1;
      i_req = 1'b1; i_addr = 32'd0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'd4;
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        if (h_valid) order.push_back(2'd2);
        if (d_valid) order.push_back(2'd1);
        if (i_valid) order.push_back(2'd0);
        @(posedge clk); #1;
      end
      h_req = 1'b0; i_req = 1'b0; d_req = 1'b0;
      checkOutput("host_count", (order.size() >= 6) ? 32'd1 : 32'd0, 32'd1);
      for (int k = 0; k < 6; k++)
        checkOutput($sformatf("host_order%0d", k),
                    (k < order.size()) ? {30'b0, order[k]} : 32'hFFFF_FFFF,
                    {30'b0, exp_order[k]});
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-port synchronous word RAM between three requesters:
  - CPU instruction fetch
  - CPU data load/store
  - optional host/loader port
- Sits between the MIPS core and the unified memory in `top`.
- Serialises accesses, returns read data with a valid pulse, and drives a stall to the core.
- Fixed priority, with a starvation guard so fetch always makes progress.

## Interface

Parameters:
- `AW`, default 6: RAM word-address width (64 words).
- `STARVE_LIMIT`, default 4: consecutive lost arbitrations after which fetch wins once.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `i_req` in 1: fetch request, level, held until `i_valid`.
- `i_addr` in 32: fetch byte address.
- `i_rdata` out 32: fetch data.
- `i_valid` out 1: 1-cycle completion pulse for fetch.
- `d_req` in 1: data request, level, held until `d_valid`.
- `d_we` in 1: data write enable.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: load data.
- `d_valid` out 1: 1-cycle completion pulse for data.
- `h_req` in 1: host request (HOST_PORT_EN only).
- `h_we` in 1: host write enable (HOST_PORT_EN only).
- `h_addr` in 32: host byte address (HOST_PORT_EN only).
- `h_wdata` in 32: host write data (HOST_PORT_EN only).
- `h_rdata` out 32: host read data (HOST_PORT_EN only).
- `h_valid` out 1: host completion pulse (HOST_PORT_EN only).
- `mem_en` out 1: RAM access enable, registered.
- `mem_we` out 1: RAM write enable, registered.
- `mem_addr` out AW: RAM word address, registered.
- `mem_wdata` out 32: RAM write data, registered.
- `mem_rdata` in 32: RAM read data, valid the cycle after `mem_en`.
- `stall` out 1: core freeze; combinational.
- `align_err` out 1: sticky misaligned-address flag.

## Operation

- States:
  - IDLE: no access in flight.
  - ISSUE: RAM command driven (`mem_en`=1).
  - RESP: result returned.
- Arbitration runs in IDLE and in RESP.
  - Any eligible request moves the FSM to ISSUE with the winner's command registered onto the `mem_*` outputs.
  - With no eligible request, the FSM goes to (or stays in) IDLE.
- Eligibility: `req` high, and the port is not the one completing in the current RESP cycle.
- Priority: host > data > fetch.
- Starvation guard:
  - `starve_cnt` counts arbitration points where `i_req` was eligible but lost.
  - When `starve_cnt` == STARVE_LIMIT, fetch wins regardless of the other requests and the counter clears.
  - The counter also clears whenever fetch wins normally.
- ISSUE state:
  - `mem_en`=1; `mem_we` = the winner's we (fetch always 0).
  - `mem_addr` = addr[AW+1:2].
- RESP state:
  - The winner's `*_valid`=1 for exactly one cycle.
  - `*_rdata` = `mem_rdata`, registered and held until that port's next completion.
  - Writes return `*_valid` with `*_rdata` unchanged.
- Misaligned access (addr[1:0] != 0):
  - The access proceeds with the truncated address.
  - `align_err` sets and stays 1 until reset.
- `stall` = (`i_req` & ~`i_valid`) | (`d_req` & ~`d_valid`).
- Host traffic never raises `stall` directly.

## Timing

- Reset values: FSM IDLE; all `*_valid`, `mem_en`, `mem_we`, `align_err` = 0; `mem_addr`, `mem_wdata`, `*_rdata` = 0; `starve_cnt` = 0.
- Latency:
  - Request high in cycle N while IDLE → ISSUE in N+1 → valid in N+2.
  - Throughput is one access per 2 cycles when requests are back-to-back (RESP → ISSUE).
- Simultaneous requests are resolved in the same arbitration cycle; the losers stay pending with `req` held.
- Dropping `req` before `valid` is illegal. Behaviour is defined only as "that access still completes and pulses valid."
- Reset asserted during ISSUE:
  - A write still commits to RAM at that edge.
  - Next cycle the FSM is IDLE and no valid is pulsed.
- Reset asserted during RESP: the valid pulse in that cycle is suppressed.

## Configuration

- Macro `HOST_PORT_EN`.
- Defined:
  - The `h_*` ports exist.
  - Host is highest priority, subject to the fetch starvation guard.
- Undefined:
  - The `h_*` ports are absent; arbitration is data > fetch.
  - All other timing is unchanged.

## Test plan

- Reset held, then released with `i_req`=1 and `i_addr`=0 → `mem_en` at cycle 1 after release, `i_valid`=1 at cycle 2, `i_rdata` = RAM[0]; `stall` high cycles 0–1.
- `d_req`=1, `d_we`=1, `d_addr`=84, `d_wdata`=8 → `mem_we`=1, `mem_addr`=21, `mem_wdata`=8 in ISSUE; a follow-up read of 84 returns 8.
- `i_req` and `d_req` both high from IDLE → data completes first, fetch completes 2 cycles later (cycle 4).
- HOST_PORT_EN: `h_req` held continuously with `i_req` high, STARVE_LIMIT=4 → fetch granted at the 5th arbitration point, then the host resumes.
- `d_addr`=82 read → access uses word 20; `align_err` rises in ISSUE and stays 1.
- `reset` pulsed low during ISSUE of a write of 0x55 to address 80 → RAM[20]=0x55, no `d_valid`, FSM IDLE.
